div_share_arb: RTL and testbench
================================

Name: div_share_arb

Overview:
- Shares one multi-cycle shift-subtract unsigned divider among N_REQ requesters.
- Arbitration is round-robin. Each requester gets a req/ack handshake for operand capture and a one-hot tagged response pulse.
- Sits between compute clients (filter, scaler and timer blocks) and the single divider datapath, so the design does not need one divider per client.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W_A, 27, dividend/quotient width.
- W_B, 16, divisor/remainder width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req  in  N_REQ  per-requester request level. Held with operands until ack.
- a_in  in  N_REQ*W_A  packed dividends. Slice i = a_in[i*W_A +: W_A].
- b_in  in  N_REQ*W_B  packed divisors. Slice i = b_in[i*W_B +: W_B].
- ack  out  N_REQ  one-hot, 1-cycle pulse: operands of requester i captured.
- rsp_vld  out  N_REQ  one-hot, 1-cycle pulse: result for requester i valid this cycle.
- q_out  out  W_A  quotient, valid with rsp_vld.
- r_out  out  W_B  remainder, valid with rsp_vld.
- dz  out  1  divide-by-zero flag, valid with rsp_vld.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE and rr pointer to 0.
  - ack, rsp_vld, q_out, r_out, dz and busy all go to 0.
  - Any in-flight division is discarded with no rsp_vld. This also applies to reset mid-RUN.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit is high, pick the winner g: the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Latch g, A=a_in[g] and B=b_in[g]. Go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD (1 cycle):
  - ack[g]=1. rr_ptr <= (g+1) mod N_REQ.
  - If B==0: go to DONE with q=all ones, r=A[W_B-1:0], dz=1.
  - Otherwise: pulse core start, clear the cycle counter, go to RUN.
- RUN:
  - The core performs one restoring step per cycle, MSB first: exactly W_A steps.
  - Step test: compare against the divisor aligned at bit W_A-1-k. If partial remainder >= that value, subtract it and shift 1 into q; otherwise shift 0 into q.
  - Go to DONE when the counter reaches W_A-1.
- DONE (1 cycle):
  - rsp_vld[g]=1 with q_out, r_out and dz driven. Go to IDLE.
  - q_out, r_out and dz hold their values until the next DONE or reset.
- Latency:
  - Request sampled in IDLE at edge T.
  - ack at T+1.
  - rsp_vld at T+W_A+2, or at T+2 when dz=1.
  - Minimum request-to-request spacing is W_A+3 cycles.
- Requester rules:
  - After ack, the requester may drop req or change operands freely.
  - If req is still high in the cycle after ack, it is a new request and competes normally.
  - A req dropped before ack is simply not granted. There is no error.
- Simultaneous events:
  - Requests arriving during LOAD/RUN/DONE wait. There is no queue beyond the req level.
  - A requester that receives rsp_vld and raises req in the same cycle is seen by IDLE next cycle. It is not favoured, because the rr pointer has already advanced.
- Width rules:
  - Internal divisor register width is W_A+W_B-1. No result saturation.
  - r_out < B is always guaranteed for B != 0.

Decomposition:
- Package div_share_pkg holds:
  - FSM state encoding (2-bit, IDLE=0, LOAD=1, RUN=2, DONE=3).
  - Default widths.
  - The round-robin pick function (N_REQ-bit mask plus pointer in, index out).
- Sub-module div_core_seq holds the divider datapath:
  - Inputs: clk, rst_n, start, a, b.
  - Outputs: q, r, done (1-cycle).
  - Counter and shift registers live inside it.
- The arbiter holds only the FSM, pointer and operand latch.

Test Plan:
- Single division: req[0], A=100, B=7 -> ack[0] at T+1; rsp_vld=4'b0001 at T+29; q_out=14, r_out=2, dz=0.
- Max operands: A=2^27-1, B=1 -> q_out=134217727, r_out=0. Then A=5, B=65535 -> q_out=0, r_out=5.
- Divide by zero: req[2], A=1234, B=0 -> rsp_vld[2] at T+2; q_out=all ones, r_out=1234, dz=1.
- Round robin: req=4'b1111 held continuously -> ack order 0,1,2,3,0; each response tagged to the matching requester.
  - Then req=4'b1001 after a grant to 3 -> next grant to 0.
- Reset mid-RUN: start 100/7, assert rst_n=0 at T+10 for 1 cycle -> no rsp_vld; busy=0 and outputs 0 after the reset edge.
  - Next request 50/5 -> q_out=10, r_out=0.
- Withdrawn request: req[1] pulsed for 1 cycle while busy -> no ack[1] and no rsp_vld[1] ever.

Source files
------------

// File: rtl/div_share_pkg.sv
// Shared types, default widths and the round-robin pick used by the divider arbiter.
package div_share_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_W_A   = 27;
    localparam int unsigned DEF_W_B   = 16;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // First set bit of mask at or above ptr, wrapping modulo n. Offsets are
    // scanned farthest-first so the nearest candidate is the last one written.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] mask,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [IDX_W-1:0] sel;
        int unsigned      p;
        int unsigned      off;
        int unsigned      j;
        sel = ptr;
        p   = 32'(ptr);
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            off = MAX_REQ - 1 - k;
            j   = (p + off) % n;
            if (off < n && mask[IDX_W'(j)]) begin
                sel = IDX_W'(j);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/div_core_seq.sv
// Restoring shift-subtract unsigned divider: one quotient bit per cycle, MSB first.
module div_core_seq
    import div_share_pkg::*;
#(
    parameter int unsigned W_A = DEF_W_A,
    parameter int unsigned W_B = DEF_W_B
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W_A-1:0] a,
    input  logic [W_B-1:0] b,
    output logic [W_A-1:0] q,
    output logic [W_B-1:0] r,
    output logic           done
);

    localparam int unsigned W_D  = W_A + W_B - 1;
    localparam int unsigned CW   = $clog2(W_A);
    localparam logic [CW-1:0] LAST = CW'(W_A - 1);

    logic [W_A-1:0] rem_q;
    logic [W_A-1:0] rem_d;
    logic [W_A-1:0] quo_q;
    logic [W_D-1:0] dvs_q;
    logic [W_D-1:0] rem_ext;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           ge;

    // dvs_q holds the divisor aligned at bit W_A-1-k during step k
    always_comb begin
        rem_ext = W_D'(rem_q);
        ge      = (rem_ext >= dvs_q);
        rem_d   = ge ? W_A'(rem_ext - dvs_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= a;
            quo_q <= '0;
            dvs_q <= W_D'(b) << (W_A - 1);
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[W_A-2:0], ge};
            dvs_q <= dvs_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

    // done flags the final step; q/r are settled after the following edge
    assign done = run_q && (cnt_q == LAST);
    assign q    = quo_q;
    assign r    = rem_q[W_B-1:0];

endmodule

// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one sequential divider among N_REQ requesters.
module div_share_arb
    import div_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned W_A   = DEF_W_A,
    parameter int unsigned W_B   = DEF_W_B
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W_A-1:0] a_in,
    input  logic [N_REQ*W_B-1:0] b_in,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     rsp_vld,
    output logic [W_A-1:0]       q_out,
    output logic [W_B-1:0]       r_out,
    output logic                 dz,
    output logic                 busy
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_e           state_q;
    logic [IDX_W-1:0] g_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] pick;
    logic [W_A-1:0]   a_q;
    logic [W_B-1:0]   b_q;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] rsp_q;
    logic [W_A-1:0]   q_out_q;
    logic [W_B-1:0]   r_out_q;
    logic             dz_q;
    logic             busy_q;
    logic             b_zero;
    logic             core_start;
    logic             core_done;
    logic [W_A-1:0]   core_q;
    logic [W_B-1:0]   core_r;

    assign pick       = rr_pick(MAX_REQ'(req), rr_q, N_REQ);
    assign b_zero     = (b_q == '0);
    assign core_start = (state_q == LOAD) && !b_zero;

    div_core_seq #(
        .W_A (W_A),
        .W_B (W_B)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .a     (a_q),
        .b     (b_q),
        .q     (core_q),
        .r     (core_r),
        .done  (core_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ack_q   <= '0;
            rsp_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            rsp_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        g_q     <= pick;
                        a_q     <= a_in[32'(pick)*W_A +: W_A];
                        b_q     <= b_in[32'(pick)*W_B +: W_B];
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    ack_q   <= ONE << g_q;
                    rr_q    <= (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
                    state_q <= b_zero ? DONE : RUN;
                end
                RUN: begin
                    if (core_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rsp_q   <= ONE << g_q;
                    q_out_q <= b_zero ? '1 : core_q;
                    r_out_q <= b_zero ? a_q[W_B-1:0] : core_r;
                    dz_q    <= b_zero;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack     = ack_q;
    assign rsp_vld = rsp_q;
    assign q_out   = q_out_q;
    assign r_out   = r_out_q;
    assign dz      = dz_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Self-checking bench for div_share_arb against a plain-arithmetic reference model.
module tb_div_share_arb;

    localparam int N  = 4;
    localparam int WA = 27;
    localparam int WB = 16;
    localparam int unsigned QMAX = (1 << WA) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*WA-1:0] a_in;
    logic [N*WB-1:0] b_in;
    logic [N-1:0]    ack;
    logic [N-1:0]    rsp_vld;
    logic [WA-1:0]   q_out;
    logic [WB-1:0]   r_out;
    logic            dz;
    logic            busy;

    int checks = 0;
    int fails  = 0;
    int m_ptr  = 0;

    div_share_arb #(
        .N_REQ (N),
        .W_A   (WA),
        .W_B   (WB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .rsp_vld (rsp_vld),
        .q_out   (q_out),
        .r_out   (r_out),
        .dz      (dz),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: round-robin winner, result values and response latency.
    function automatic int m_pick(input logic [N-1:0] mask, input int ptr);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = mask >> ((ptr + k) % N);
            if (s[0]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int unsigned m_q(input int unsigned a, input int unsigned b);
        return (b == 0) ? QMAX : a / b;
    endfunction

    function automatic int unsigned m_r(input int unsigned a, input int unsigned b);
        return (b == 0) ? (a & 32'hFFFF) : a % b;
    endfunction

    function automatic int m_rsp_n(input int unsigned b);
        return (b == 0) ? 3 : WA + 3;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    // Single-requester transaction; records what the DUT did, checks nothing.
    task automatic issue(input int idx, input int unsigned a, input int unsigned b,
                         output int ack_n, output logic [N-1:0] ack_v,
                         output int rsp_n, output logic [N-1:0] rsp_v,
                         output int unsigned q, output int unsigned r, output logic z);
        ack_n = -1; rsp_n = -1; ack_v = '0; rsp_v = '0; q = 0; r = 0; z = 1'b0;
        a_in[idx*WA +: WA] = WA'(a);
        b_in[idx*WB +: WB] = WB'(b);
        req[idx] = 1'b1;
        for (int n = 1; n <= 80 && rsp_n < 0; n++) begin
            @(posedge clk); #1;
            if (ack !== '0 && ack_n < 0) begin
                ack_n = n; ack_v = ack; req[idx] = 1'b0;
            end
            if (rsp_vld !== '0) begin
                rsp_n = n; rsp_v = rsp_vld; q = 32'(q_out); r = 32'(r_out); z = dz;
            end
        end
        req[idx] = 1'b0;
        m_ptr = (idx + 1) % N;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== '0)     begin fails++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (rsp_vld !== '0) begin fails++; $display("FAIL reset_rsp_vld: got %b expected 0", rsp_vld); end
        checks++; if (q_out !== '0)   begin fails++; $display("FAIL reset_q_out: got %0d expected 0", q_out); end
        checks++; if (r_out !== '0)   begin fails++; $display("FAIL reset_r_out: got %0d expected 0", r_out); end
        checks++; if (dz !== 1'b0)    begin fails++; $display("FAIL reset_dz: got %b expected 0", dz); end
        checks++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        m_ptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_one(input string nm, input int idx, input int unsigned a, input int unsigned b);
        int an, rn; logic [N-1:0] av, rv; int unsigned q, r; logic z;
        issue(idx, a, b, an, av, rn, rv, q, r, z);
        checks++; if (an !== 2)           begin fails++; $display("FAIL %s_ack_cycle: got %0d expected 2", nm, an); end
        checks++; if (av !== oh(idx))     begin fails++; $display("FAIL %s_ack_tag: got %b expected %b", nm, av, oh(idx)); end
        checks++; if (rn !== m_rsp_n(b))  begin fails++; $display("FAIL %s_rsp_cycle: got %0d expected %0d", nm, rn, m_rsp_n(b)); end
        checks++; if (rv !== oh(idx))     begin fails++; $display("FAIL %s_rsp_tag: got %b expected %b", nm, rv, oh(idx)); end
        checks++; if (q !== m_q(a, b))    begin fails++; $display("FAIL %s_q: a=%0d b=%0d got %0d expected %0d", nm, a, b, q, m_q(a, b)); end
        checks++; if (r !== m_r(a, b))    begin fails++; $display("FAIL %s_r: a=%0d b=%0d got %0d expected %0d", nm, a, b, r, m_r(a, b)); end
        checks++; if (z !== (b == 0))     begin fails++; $display("FAIL %s_dz: got %b expected %b", nm, z, (b == 0)); end
    endtask

    task automatic test_single();
        test_one("single", 0, 100, 7);
    endtask

    task automatic test_max_operands();
        test_one("max_a", 1, QMAX, 1);
        test_one("max_b", 3, 5, 65535);
    endtask

    task automatic test_div_zero();
        test_one("dz", 2, 1234, 0);
        @(posedge clk); #1;
        checks++; if (rsp_vld !== '0)     begin fails++; $display("FAIL dz_pulse_width: got %b expected 0", rsp_vld); end
        checks++; if (32'(q_out) !== QMAX) begin fails++; $display("FAIL dz_hold_q: got %0d expected %0d", q_out, QMAX); end
        checks++; if (dz !== 1'b1)        begin fails++; $display("FAIL dz_hold_dz: got %b expected 1", dz); end
    endtask

    task automatic test_random();
        int unsigned a, b;
        for (int i = 0; i < 10; i++) begin
            a = $urandom & QMAX;
            case ($urandom_range(0, 3))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom & 32'hFFFF;
            endcase
            test_one("rand", $urandom_range(0, N - 1), a, b);
        end
    endtask

    task automatic test_round_robin();
        int an, rn; logic [N-1:0] av, rv; int unsigned q, r; logic z;
        int unsigned opa[N];
        int unsigned opb[N];
        int exp_g, t, last_t, prev_b;
        bit got;
        // zero-divisor request on 3 brings the pointer back to 0
        issue(3, 11, 0, an, av, rn, rv, q, r, z);
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom & QMAX;
            opb[i] = $urandom_range(1, 65535);
            a_in[i*WA +: WA] = WA'(opa[i]);
            b_in[i*WB +: WB] = WB'(opb[i]);
        end
        req = '1;
        t = 0; last_t = 0; prev_b = 1;
        for (int k = 0; k < 9; k++) begin
            exp_g = m_pick(req, m_ptr);
            got = 0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(posedge clk); #1; t++;
                if (ack !== '0) got = 1;
            end
            checks++; if (ack !== oh(exp_g)) begin fails++; $display("FAIL rr_ack_%0d: got %b expected %b", k, ack, oh(exp_g)); end
            if (k > 0) begin
                checks++;
                if (t - last_t !== m_rsp_n(prev_b) - 1 + 1)
                    begin fails++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", k, t - last_t, m_rsp_n(prev_b)); end
            end
            last_t = t;
            prev_b = opb[exp_g];
            m_ptr = (exp_g + 1) % N;
            req = (k < 7) ? 4'b1111 : (k == 7) ? 4'b1001 : 4'b0000;
            got = 0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(posedge clk); #1; t++;
                if (rsp_vld !== '0) got = 1;
            end
            checks++; if (rsp_vld !== oh(exp_g)) begin fails++; $display("FAIL rr_rsp_tag_%0d: got %b expected %b", k, rsp_vld, oh(exp_g)); end
            checks++; if (32'(q_out) !== m_q(opa[exp_g], opb[exp_g]))
                begin fails++; $display("FAIL rr_q_%0d: got %0d expected %0d", k, q_out, m_q(opa[exp_g], opb[exp_g])); end
            checks++; if (32'(r_out) !== m_r(opa[exp_g], opb[exp_g]))
                begin fails++; $display("FAIL rr_r_%0d: got %0d expected %0d", k, r_out, m_r(opa[exp_g], opb[exp_g])); end
        end
        req = '0;
    endtask

    task automatic test_withdrawn();
        bit seen_bad, busy_ok;
        int rn;
        int unsigned q, r;
        rn = -1; q = 0; r = 0; seen_bad = 0; busy_ok = 0;
        a_in[0 +: WA] = WA'(1000);
        b_in[0 +: WB] = WB'(3);
        req[0] = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (ack[0] === 1'b1) req[0] = 1'b0;
            if (n == 6) begin req[1] = 1'b1; busy_ok = (busy === 1'b1); end
            if (n == 7) req[1] = 1'b0;
            if (ack[1] !== 1'b0 || rsp_vld[1] !== 1'b0) seen_bad = 1;
            if (rsp_vld[0] === 1'b1) begin rn = n; q = 32'(q_out); r = 32'(r_out); end
        end
        m_ptr = 1;
        checks++; if (busy_ok !== 1'b1) begin fails++; $display("FAIL wd_busy: got %b expected 1", busy_ok); end
        checks++; if (seen_bad !== 1'b0) begin fails++; $display("FAIL wd_no_grant1: got %b expected 0", seen_bad); end
        checks++; if (rn !== m_rsp_n(3)) begin fails++; $display("FAIL wd_rsp0_cycle: got %0d expected %0d", rn, m_rsp_n(3)); end
        checks++; if (q !== m_q(1000, 3)) begin fails++; $display("FAIL wd_q: got %0d expected %0d", q, m_q(1000, 3)); end
        checks++; if (r !== m_r(1000, 3)) begin fails++; $display("FAIL wd_r: got %0d expected %0d", r, m_r(1000, 3)); end
    endtask

    task automatic test_reset_mid_run();
        bit seen, got;
        int exp_g;
        a_in[2*WA +: WA] = WA'(100);
        b_in[2*WB +: WB] = WB'(7);
        req[2] = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n == 2) req[2] = 1'b0;
            if (n == 10) rst_n = 1'b0;
        end
        checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (q_out !== '0)     begin fails++; $display("FAIL mid_q_out: got %0d expected 0", q_out); end
        checks++; if (r_out !== '0)     begin fails++; $display("FAIL mid_r_out: got %0d expected 0", r_out); end
        checks++; if (dz !== 1'b0)      begin fails++; $display("FAIL mid_dz: got %b expected 0", dz); end
        rst_n = 1'b1;
        m_ptr = 0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (rsp_vld !== '0) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_rsp: got %b expected 0", seen); end
        // 1 and 3 both ask; a freshly reset pointer selects 1
        a_in[1*WA +: WA] = WA'(50); b_in[1*WB +: WB] = WB'(5);
        a_in[3*WA +: WA] = WA'(9);  b_in[3*WB +: WB] = WB'(2);
        req = 4'b1010;
        exp_g = m_pick(req, m_ptr);
        got = 0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(posedge clk); #1;
            if (ack !== '0) got = 1;
        end
        req = '0;
        checks++; if (ack !== oh(exp_g)) begin fails++; $display("FAIL mid_ptr_grant: got %b expected %b", ack, oh(exp_g)); end
        got = 0;
        for (int w = 0; w < 60 && !got; w++) begin
            @(posedge clk); #1;
            if (rsp_vld !== '0) got = 1;
        end
        checks++; if (rsp_vld !== oh(exp_g)) begin fails++; $display("FAIL mid_rsp_tag: got %b expected %b", rsp_vld, oh(exp_g)); end
        checks++; if (32'(q_out) !== m_q(50, 5)) begin fails++; $display("FAIL mid_q: got %0d expected %0d", q_out, m_q(50, 5)); end
        checks++; if (32'(r_out) !== m_r(50, 5)) begin fails++; $display("FAIL mid_r: got %0d expected %0d", r_out, m_r(50, 5)); end
        checks++; if (dz !== 1'b0) begin fails++; $display("FAIL mid_dz_after: got %b expected 0", dz); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_operands();
        test_div_zero();
        test_random();
        test_round_robin();
        test_withdrawn();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
